load_store_unit: RTL and testbench

Memory-stage controller between the EX/MEM pipeline register and `Data_Memory`. It accepts one load or store request at a time over a valid/ready handshake and decodes RV64 `funct3` sizes. Sub-word stores are performed as read-modify-write, because `Data_Memory` always writes 8 bytes. Loads are returned sign- or zero-extended, with an error flag for out-of-range or illegal accesses.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_load_ext.sv | 26 ++
 rtl/load_store_unit.sv | 169 ++++++++++++++++
 tb/tb_load_store_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, RV64 funct3 size codes
// and the helpers that bound legal memory accesses.
package lsu_pkg;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE = 2'd0;
  localparam lsu_state_t ST_RD   = 2'd1;
  localparam lsu_state_t ST_WR   = 2'd2;
  localparam lsu_state_t ST_RESP = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Highest start address whose full 8-byte window still fits in memory.
  function automatic logic [63:0] lsu_addr_limit(input logic [63:0] mem_bytes);
    return mem_bytes - 64'd8;
  endfunction

  function automatic logic lsu_f3_legal(input logic is_write, input logic [2:0] f3);
    logic legal;
    if (is_write) begin
      legal = (f3[2] == 1'b0);
    end else begin
      legal = (f3 != 3'b111);
    end
    return legal;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational size/sign extraction of load data (little-endian, LSB = byte at addr).
// Kept standalone so the MEM/WB forwarding path can reuse it.
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [2:0]        funct3_i,
  output logic [DATA_W-1:0] data_o
);

  // Select width and extension type from funct3.
  always_comb begin
    case (funct3_i)
      F3_B:    data_o = {{(DATA_W-8){data_i[7]}},   data_i[7:0]};
      F3_H:    data_o = {{(DATA_W-16){data_i[15]}}, data_i[15:0]};
      F3_W:    data_o = {{(DATA_W-32){data_i[31]}}, data_i[31:0]};
      F3_BU:   data_o = {{(DATA_W-8){1'b0}},        data_i[7:0]};
      F3_HU:   data_o = {{(DATA_W-16){1'b0}},       data_i[15:0]};
      F3_WU:   data_o = {{(DATA_W-32){1'b0}},       data_i[31:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage controller: one load/store in flight, sub-word stores done as
// read-modify-write because Data_Memory always writes a full 8-byte word.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Write_Data,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] Read_Data
);

  localparam logic [63:0]       LIMIT_64   = lsu_addr_limit(64'(MEM_BYTES));
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = LIMIT_64[ADDR_W-1:0];

  lsu_state_t        state_q, state_d;
  logic              write_q, write_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

  logic              req_err_s;
  logic [DATA_W-1:0] ext_s;
  logic [DATA_W-1:0] merge_s;

  assign req_err_s = (req_addr > ADDR_LIMIT) || !lsu_f3_legal(req_write, req_funct3);

  // The read buffer is captured on the same edge the response is registered,
  // so extension is taken straight from Read_Data while in RD.
  lsu_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .data_i   (Read_Data),
    .funct3_i (funct3_q),
    .data_o   (ext_s)
  );

  // Store merge: replace the low bytes of the old word, keep the rest.
  always_comb begin
    merge_s = rbuf_q;
    case (funct3_q)
      F3_B:    merge_s[7:0]  = wdata_q[7:0];
      F3_H:    merge_s[15:0] = wdata_q[15:0];
      F3_W:    merge_s[31:0] = wdata_q[31:0];
      F3_D:    merge_s       = wdata_q;
      default: merge_s       = wdata_q;
    endcase
  end

  // Next-state, request latch and response register computation.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (req_err_s) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = {DATA_W{1'b0}};
          end else if (req_write && (req_funct3 == F3_D)) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        rbuf_d = Read_Data;
        if (write_q) begin
          state_d = ST_WR;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = ext_s;
        end
      end
      ST_WR: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = {DATA_W{1'b0}};
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory-side strobes; forced quiet while reset is high so an aborted store never writes.
  always_comb begin
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Mem_Addr   = {ADDR_W{1'b0}};
    Write_Data = {DATA_W{1'b0}};
    if (!reset && (state_q == ST_RD)) begin
      MemRead  = 1'b1;
      Mem_Addr = addr_q;
    end else if (!reset && (state_q == ST_WR)) begin
      MemWrite   = 1'b1;
      Mem_Addr   = addr_q;
      Write_Data = merge_s;
    end else begin
      MemRead = 1'b0;
    end
  end

  // State and latch registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= {ADDR_W{1'b0}};
      wdata_q      <= {DATA_W{1'b0}};
      rbuf_q       <= {DATA_W{1'b0}};
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE) && !reset;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array memory model, directed
// cases with literal expectations, then randomized traffic against a reference model.
module tb_load_store_unit;

  localparam int MB = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] Mem_Addr;
  logic [63:0] Write_Data;
  logic        MemWrite;
  logic        MemRead;
  logic [63:0] Read_Data;

  load_store_unit #(.ADDR_W(64), .DATA_W(64), .MEM_BYTES(MB)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .Mem_Addr(Mem_Addr), .Write_Data(Write_Data), .MemWrite(MemWrite),
    .MemRead(MemRead), .Read_Data(Read_Data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic [7:0]  mem [MB];
  logic [7:0]  exp_mem [MB];
  bit          mem_ready = 1'b0;
  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  int          cur_kind = 0;   // 0 none, 1 load, 2 store, 3 errored request
  bit          run_cmp = 1'b0;
  logic [63:0] last_rdata = 64'd0;
  logic        last_err = 1'b0;
  int          last_resp_cyc = 0;
  int          last_accept = 0;

  function automatic logic [7:0] init_byte(input int j);
    return (j % 8 == 0) ? 8'(j / 8 + 4) : 8'h00;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h required %h", name, got, want);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Data_Memory: combinational read, write on negedge.
  always_comb begin
    Read_Data = 64'd0;
    for (int i = 0; i < 8; i++)
      if (Mem_Addr + 64'(i) < 64'(MB)) Read_Data[8*i +: 8] = mem[int'(Mem_Addr) + i];
  end

  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int j = 0; j < MB; j++) mem[j] = init_byte(j);
      mem_ready = 1'b1;
    end else if (MemWrite) begin
      for (int i = 0; i < 8; i++)
        if (Mem_Addr + 64'(i) < 64'(MB)) mem[int'(Mem_Addr) + i] = Write_Data[8*i +: 8];
    end
  end

  // Reference model: what a request must return and after how many cycles.
  function automatic void model(input logic w, input logic [2:0] f3, input logic [63:0] a,
                                output logic [63:0] rd, output logic err, output int lat);
    int          size;
    logic        legal;
    logic [63:0] v;
    size  = 1 << f3[1:0];
    legal = w ? (f3 < 3'd4) : (f3 != 3'd7);
    err   = !legal || (a > 64'(MB - 8));
    rd    = 64'd0;
    lat   = 0;
    if (err) return;
    if (w) begin
      lat = (size == 8) ? 1 : 2;
    end else begin
      v = 64'd0;
      for (int i = 0; i < size; i++) v |= 64'(exp_mem[int'(a) + i]) << (8 * i);
      if (f3[2] == 1'b0 && size < 8)
        v = $unsigned($signed(v << (64 - 8 * size)) >>> (64 - 8 * size));
      rd  = v;
      lat = 1;
    end
  endfunction

  task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input bit wait_done, input bit expect_resp);
    logic [63:0] rd;
    logic        err;
    int          lat;
    int          n;
    bit          r;
    model(w, f3, a, rd, err, lat);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    n = 0;
    r = 1'b0;
    while (!r && n < 50) begin
      @(negedge clk);
      r = req_ready;
      @(posedge clk);
      n++;
    end
    #1;
    req_valid = 1'b0;
    if (!r) begin
      fail_now("accept_timeout");
      return;
    end
    last_accept = cyc;
    cur_kind = err ? 3 : (w ? 2 : 1);
    if (expect_resp) begin
      q.push_back('{due: cyc + lat, rdata: rd, err: err});
      if (w && !err)
        for (int i = 0; i < (1 << f3[1:0]); i++) exp_mem[int'(a) + i] = wd[8*i +: 8];
    end
    if (wait_done) begin
      n = 0;
      while (q.size() > 0 && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (q.size() > 0) fail_now("resp_timeout");
    end
  endtask

  // Per-cycle comparison of the response channel against the model queue.
  always @(negedge clk) begin
    bit ev;
    if (!reset && run_cmp) begin
      ev = (q.size() > 0) && (q[0].due == cyc);
      check("resp_valid", 64'(resp_valid), 64'(ev));
      if (resp_valid) begin
        last_rdata    = resp_rdata;
        last_err      = resp_err;
        last_resp_cyc = cyc;
      end
      if (ev) begin
        check("resp_rdata", resp_rdata, q[0].rdata);
        check("resp_err", 64'(resp_err), 64'(q[0].err));
        void'(q.pop_front());
      end else if (q.size() > 0 && q[0].due < cyc) begin
        void'(q.pop_front());
      end
      if (cur_kind == 1) check("load_no_write", 64'(MemWrite), 64'd0);
      if (cur_kind == 3) begin
        check("err_no_read", 64'(MemRead), 64'd0);
        check("err_no_write", 64'(MemWrite), 64'd0);
      end
    end
  end

  initial begin
    int a1;
    int n;
    logic        w;
    logic [2:0]  f3;
    logic [63:0] a;
    for (int j = 0; j < MB; j++) exp_mem[j] = init_byte(j);

    // Reset state
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_memread", 64'(MemRead), 64'd0);
    check("rst_memwrite", 64'(MemWrite), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(req_ready), 64'd1);
    check("post_rst_valid", 64'(resp_valid), 64'd0);
    check("post_rst_rdata", resp_rdata, 64'd0);
    check("post_rst_err", 64'(resp_err), 64'd0);
    run_cmp = 1'b1;
    @(posedge clk); #1;

    issue(1'b0, 3'b011, 64'd8, 64'd0, 1'b1, 1'b1);
    check("ld8", last_rdata, 64'd5);
    check("ld8_lat", 64'(last_resp_cyc - last_accept), 64'd1);

    issue(1'b1, 3'b000, 64'd8, 64'hAA, 1'b1, 1'b1);
    check("sb_lat", 64'(last_resp_cyc - last_accept), 64'd2);
    issue(1'b0, 3'b011, 64'd8, 64'd0, 1'b1, 1'b1);
    check("ld8_after_sb", last_rdata, 64'hAA);
    issue(1'b0, 3'b011, 64'd16, 64'd0, 1'b1, 1'b1);
    check("ld16", last_rdata, 64'd6);

    issue(1'b1, 3'b000, 64'd0, 64'hFF, 1'b1, 1'b1);
    issue(1'b0, 3'b000, 64'd0, 64'd0, 1'b1, 1'b1);
    check("lb0", last_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(1'b0, 3'b100, 64'd0, 64'd0, 1'b1, 1'b1);
    check("lbu0", last_rdata, 64'hFF);

    issue(1'b1, 3'b011, 64'd16, 64'h1122334455667788, 1'b1, 1'b1);
    check("sd_lat", 64'(last_resp_cyc - last_accept), 64'd1);
    issue(1'b0, 3'b010, 64'd16, 64'd0, 1'b1, 1'b1);
    check("lw16", last_rdata, 64'h55667788);
    issue(1'b0, 3'b001, 64'd20, 64'd0, 1'b1, 1'b1);
    check("lh20", last_rdata, 64'h3344);
    issue(1'b0, 3'b110, 64'd20, 64'd0, 1'b1, 1'b1);
    check("lwu20", last_rdata, 64'h11223344);

    issue(1'b0, 3'b011, 64'd60, 64'd0, 1'b1, 1'b1);
    check("ld60_err", 64'(last_err), 64'd1);
    check("ld60_rdata", last_rdata, 64'd0);
    check("err_lat", 64'(last_resp_cyc - last_accept), 64'd0);
    issue(1'b0, 3'b111, 64'd0, 64'd0, 1'b1, 1'b1);
    check("f3_111_err", 64'(last_err), 64'd1);
    issue(1'b0, 3'b011, 64'd56, 64'd0, 1'b1, 1'b1);
    check("ld56_edge", last_rdata, 64'd11);
    check("ld56_err", 64'(last_err), 64'd0);
    issue(1'b1, 3'b100, 64'd0, 64'd0, 1'b1, 1'b1);
    check("store_f3_100_err", 64'(last_err), 64'd1);

    // Request held while a sub-word store is busy
    issue(1'b1, 3'b000, 64'd24, 64'h5A, 1'b0, 1'b1);
    a1 = last_accept;
    issue(1'b0, 3'b011, 64'd24, 64'd0, 1'b1, 1'b1);
    check("held_accept_cycle", 64'(last_accept - a1), 64'd4);
    check("ld24_after_sb", last_rdata, 64'h5A);

    // Reset pulsed in WR before the write negedge: store aborted
    issue(1'b1, 3'b001, 64'd0, 64'hBEEF, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", 64'(req_ready), 64'd1);
    for (int j = 0; j < 8; j++) check("abort_mem", 64'(mem[j]), 64'(exp_mem[j]));
    @(posedge clk); #1;

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) a = {32'($urandom), 32'($urandom)};
      else a = 64'($urandom_range(0, 60));
      issue(w, f3, a, {32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)), 1'b1);
    end
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() > 0) fail_now("final_drain");
    @(negedge clk);
    for (int j = 0; j < MB; j++) check("final_mem", 64'(mem[j]), 64'(exp_mem[j]));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
